// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared encodings for the execute stage:
//   alu_op_e   - ALU operation select (ADD = b+a, SUB = b-a, AND, XOR)
//   cond_e     - branch / cmov condition select
//   CC_ZF/SF/OF - bit positions inside the {ZF,SF,OF} condition-code vector
//   CC_RESET_DEFAULT - condition-code value after reset (ZF set)
//   cond_eval()      - evaluates a condition against a condition-code vector
// -----------------------------------------------------------------------------
package alu_pkg;

    typedef enum logic [1:0] {
        ALU_ADD = 2'd0,
        ALU_SUB = 2'd1,
        ALU_AND = 2'd2,
        ALU_XOR = 2'd3
    } alu_op_e;

    typedef enum logic [2:0] {
        C_ALWAYS = 3'd0,
        C_LE     = 3'd1,
        C_L      = 3'd2,
        C_E      = 3'd3,
        C_NE     = 3'd4,
        C_GE     = 3'd5,
        C_G      = 3'd6,
        C_NEVER  = 3'd7
    } cond_e;

    localparam int CC_ZF = 2;
    localparam int CC_SF = 1;
    localparam int CC_OF = 0;

    localparam logic [2:0] CC_RESET_DEFAULT = 3'b100;

    // Signed comparisons follow from the flags of (b - a): "less" is SF != OF.
    function automatic logic cond_eval(input cond_e cond, input logic [2:0] cc);
        logic zf;
        logic lt;
        zf = cc[CC_ZF];
        lt = cc[CC_SF] ^ cc[CC_OF];
        unique case (cond)
            C_ALWAYS: cond_eval = 1'b1;
            C_LE:     cond_eval = lt | zf;
            C_L:      cond_eval = lt;
            C_E:      cond_eval = zf;
            C_NE:     cond_eval = !zf;
            C_GE:     cond_eval = !lt;
            C_G:      cond_eval = !lt && !zf;
            C_NEVER:  cond_eval = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_core.sv
// -----------------------------------------------------------------------------
// alu_core
// Purely combinational ALU: result and {ZF,SF,OF} from op, a, b.
// ADD and SUB share one ripple-carry adder; SUB feeds ~a with carry-in 1.
// Ports:
//   op_i      ALU operation (alu_op_e)
//   a_i, b_i  operands (signed two's complement, WIDTH bits)
//   result_o  b op a, modulo 2^WIDTH
//   flags_o   {ZF,SF,OF}; OF = carry into MSB ^ carry out of MSB for ADD/SUB,
//             0 for logic ops
// -----------------------------------------------------------------------------
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  alu_op_e            op_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic [WIDTH-1:0]   result_o,
    output logic [2:0]         flags_o
);

    logic             is_sub;
    logic [WIDTH-1:0] a_eff;
    logic [WIDTH-1:0] sum;
    logic [WIDTH:0]   carry;
    logic             add_of;

    assign is_sub = (op_i == ALU_SUB);
    assign a_eff  = is_sub ? ~a_i : a_i;

    // Explicit ripple chain so the carry into the MSB is directly observable.
    always_comb begin
        // NOTE: every signal written here gets a value before any branch or
        // loop, otherwise synthesis infers a latch to hold the old value.
        carry    = '0;
        sum      = '0;
        carry[0] = is_sub;
        for (int i = 0; i < WIDTH; i++) begin
            sum[i]     = b_i[i] ^ a_eff[i] ^ carry[i];
            carry[i+1] = (b_i[i] & a_eff[i]) | (carry[i] & (b_i[i] ^ a_eff[i]));
        end
    end

    assign add_of = carry[WIDTH-1] ^ carry[WIDTH];

    always_comb begin
        result_o       = sum;
        flags_o        = '0;
        flags_o[CC_OF] = 1'b0;
        unique case (op_i)
            ALU_ADD, ALU_SUB: begin
                result_o       = sum;
                flags_o[CC_OF] = add_of;
            end
            ALU_AND: result_o = b_i & a_i;
            ALU_XOR: result_o = b_i ^ a_i;
        endcase
        flags_o[CC_ZF] = (result_o == '0);
        flags_o[CC_SF] = result_o[WIDTH-1];
    end

endmodule

// File: rtl/alu_cc_execute.sv
// -----------------------------------------------------------------------------
// alu_cc_execute
// Registered execute stage: one ALU op per accepted input, a one-deep output
// register towards the memory stage, and the architectural condition codes.
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   in_valid / in_ready upstream handshake (in_ready = !out_valid || out_ready)
//   in_op, in_a, in_b   ALU op and operands (result = b op a)
//   in_set_cc           load cc_q with this op's flags on accept
//   in_cond             condition evaluated against cc_q before this op's update
//   out_valid/out_ready downstream handshake
//   out_result, out_flags, out_cnd  registered result, flags, condition outcome
//   cc_q                architectural {ZF,SF,OF}
//   stat_ops, stat_ovf  accept / overflow counters (only with EXEC_STATS_EN)
// Build option: define EXEC_STATS_EN to add the statistics counters.
// -----------------------------------------------------------------------------
module alu_cc_execute
    import alu_pkg::*;
#(
    parameter int         WIDTH    = 64,
    parameter logic [2:0] CC_RESET = CC_RESET_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_set_cc,
    input  logic [2:0]       in_cond,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [2:0]       out_flags,
    output logic             out_cnd,
`ifdef EXEC_STATS_EN
    output logic [31:0]      stat_ops,
    output logic [31:0]      stat_ovf,
`endif
    output logic [2:0]       cc_q
);

    logic             valid_q,  valid_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [2:0]       flags_q,  flags_d;
    logic             cnd_q,    cnd_d;
    logic [2:0]       cc_d;

    logic             accept;
    logic [WIDTH-1:0] alu_result;
    logic [2:0]       alu_flags;

    alu_core #(
        .WIDTH (WIDTH)
    ) u_alu_core (
        .op_i     (alu_op_e'(in_op)),
        .a_i      (in_a),
        .b_i      (in_b),
        .result_o (alu_result),
        .flags_o  (alu_flags)
    );

    // The slot is free when empty or being drained this cycle.
    assign in_ready = !valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    always_comb begin
        valid_d  = valid_q;
        result_d = result_q;
        flags_d  = flags_q;
        cnd_d    = cnd_q;
        cc_d     = cc_q;
        if (accept) begin
            valid_d  = 1'b1;
            result_d = alu_result;
            flags_d  = alu_flags;
            // Uses cc_q as it stands, i.e. before this op's own update.
            cnd_d    = cond_eval(cond_e'(in_cond), cc_q);
            if (in_set_cc) begin
                cc_d = alu_flags;
            end
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of its inputs, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the data registers are reset too (not just valid) because
            // their post-reset value is architecturally visible.
            valid_q  <= 1'b0;
            result_q <= '0;
            flags_q  <= '0;
            cnd_q    <= 1'b0;
            cc_q     <= CC_RESET;
        end else begin
            valid_q  <= valid_d;
            result_q <= result_d;
            flags_q  <= flags_d;
            cnd_q    <= cnd_d;
            cc_q     <= cc_d;
        end
    end

    assign out_valid  = valid_q;
    assign out_result = result_q;
    assign out_flags  = flags_q;
    assign out_cnd    = cnd_q;

`ifdef EXEC_STATS_EN
    logic [31:0] stat_ops_q, stat_ovf_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_ops_q <= '0;
            stat_ovf_q <= '0;
        end else if (accept) begin
            stat_ops_q <= stat_ops_q + 32'd1;
            if (alu_flags[CC_OF]) begin
                stat_ovf_q <= stat_ovf_q + 32'd1;
            end
        end
    end

    assign stat_ops = stat_ops_q;
    assign stat_ovf = stat_ovf_q;
`endif

endmodule

// File: tb/tb_alu_cc_execute.sv
// -----------------------------------------------------------------------------
// tb_alu_cc_execute
// Directed scenarios followed by randomized traffic, all compared against a
// behavioural model that computes results with plain signed arithmetic.
// Build option: define EXEC_STATS_EN to also check the statistics counters.
// -----------------------------------------------------------------------------
module tb_alu_cc_execute;

    localparam int W = 64;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [1:0]   in_op;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_set_cc;
    logic [2:0]   in_cond;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_result;
    logic [2:0]   out_flags;
    logic         out_cnd;
    logic [2:0]   cc_q;
`ifdef EXEC_STATS_EN
    logic [31:0]  stat_ops;
    logic [31:0]  stat_ovf;
`endif

    alu_cc_execute #(
        .WIDTH    (W),
        .CC_RESET (3'b100)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_set_cc  (in_set_cc),
        .in_cond    (in_cond),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_flags  (out_flags),
        .out_cnd    (out_cnd),
`ifdef EXEC_STATS_EN
        .stat_ops   (stat_ops),
        .stat_ovf   (stat_ovf),
`endif
        .cc_q       (cc_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic         m_known = 1'b0;
    logic         m_valid;
    logic [W-1:0] m_result;
    logic [2:0]   m_flags;
    logic         m_cnd;
    logic [2:0]   m_cc;
    logic [31:0]  m_ops;
    logic [31:0]  m_ovf;
    int           accepts;

    // Returns {ZF,SF,OF,result}; overflow judged from operand/result signs.
    function automatic logic [W+2:0] ref_alu(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] r;
        logic         of;
        of = 1'b0;
        case (op)
            2'd0: begin
                r  = b + a;
                of = (a[W-1] == b[W-1]) && (r[W-1] != b[W-1]);
            end
            2'd1: begin
                r  = b - a;
                of = (a[W-1] != b[W-1]) && (r[W-1] != b[W-1]);
            end
            2'd2:    r = b & a;
            default: r = b ^ a;
        endcase
        return {(r == '0), r[W-1], of, r};
    endfunction

    function automatic logic ref_cond(input logic [2:0] c, input logic [2:0] cc);
        logic zf, less;
        zf   = cc[2];
        less = cc[1] != cc[0];
        case (c)
            3'd0:    return 1'b1;
            3'd1:    return less || zf;
            3'd2:    return less;
            3'd3:    return zf;
            3'd4:    return !zf;
            3'd5:    return !less;
            3'd6:    return !less && !zf;
            default: return 1'b0;
        endcase
    endfunction

    // One clock: drive inputs, check in_ready, advance model, check outputs.
    task automatic cycle(input logic r, input logic v, input logic [1:0] op,
                         input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic sc, input logic [2:0] cond, input logic ordy);
        logic [W+2:0] alu;
        logic         acc;
        rst = r; in_valid = v; in_op = op; in_a = a; in_b = b;
        in_set_cc = sc; in_cond = cond; out_ready = ordy;
        #1;
        if (m_known) check("in_ready", W'(in_ready), W'(!m_valid || ordy));
        alu = ref_alu(op, a, b);
        acc = v && (!m_valid || ordy);
        @(posedge clk);
        #1;
        if (r) begin
            m_known = 1'b1; m_valid = 1'b0; m_result = '0; m_flags = '0;
            m_cnd = 1'b0; m_cc = 3'b100; m_ops = '0; m_ovf = '0;
        end else if (acc) begin
            accepts++;
            m_cnd    = ref_cond(cond, m_cc);
            m_valid  = 1'b1;
            m_result = alu[W-1:0];
            m_flags  = alu[W+2:W];
            if (sc) m_cc = alu[W+2:W];
            m_ops++;
            if (alu[W]) m_ovf++;
        end else if (ordy) begin
            m_valid = 1'b0;
        end
        check("out_valid", W'(out_valid), W'(m_valid));
        if (m_valid) begin
            check("out_result", out_result, m_result);
            check("out_flags", W'(out_flags), W'(m_flags));
            check("out_cnd", W'(out_cnd), W'(m_cnd));
        end
        check("cc_q", W'(cc_q), W'(m_cc));
`ifdef EXEC_STATS_EN
        check("stat_ops", W'(stat_ops), W'(m_ops));
        check("stat_ovf", W'(stat_ovf), W'(m_ovf));
`endif
    endtask

    function automatic logic [W-1:0] pick_operand();
        logic [W-1:0] edges [6];
        edges[0] = '0;
        edges[1] = 64'h1;
        edges[2] = 64'h7FFF_FFFF_FFFF_FFFF;
        edges[3] = 64'h8000_0000_0000_0000;
        edges[4] = 64'hFFFF_FFFF_FFFF_FFFF;
        edges[5] = 64'h5;
        if ($urandom_range(0, 3) == 0) return edges[$urandom_range(0, 5)];
        return {$urandom, $urandom};
    endfunction

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0;
        in_set_cc = 1'b0; in_cond = '0; out_ready = 1'b0;
        accepts = 0;
        @(posedge clk);
        #1;

        // Reset held two cycles with a valid op presented.
        cycle(1, 1, 2'd0, 64'd3, 64'd4, 1, 3'd0, 1);
        cycle(1, 1, 2'd0, 64'd3, 64'd4, 1, 3'd0, 1);
        check("rst_out_valid", W'(out_valid), '0);
        check("rst_out_result", out_result, '0);
        check("rst_cc", W'(cc_q), W'(3'b100));
        rst = 1'b0; in_valid = 1'b0;
        #1;
        check("rst_in_ready", W'(in_ready), W'(1'b1));

        // Signed overflow on ADD.
        cycle(0, 1, 2'd0, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 1, 3'd0, 1);
        check("ovf_result", out_result, 64'h8000_0000_0000_0000);
        check("ovf_flags", W'(out_flags), W'(3'b011));
        check("ovf_cc", W'(cc_q), W'(3'b011));

        // Clear CC, then SUB to zero sees the old (ZF=0) codes.
        cycle(0, 1, 2'd0, 64'd1, 64'd1, 1, 3'd0, 1);
        check("clr_cc", W'(cc_q), W'(3'b000));
        cycle(0, 1, 2'd1, 64'd5, 64'd5, 1, 3'd3, 1);
        check("sub0_result", out_result, '0);
        check("sub0_cnd_old_cc", W'(out_cnd), '0);
        check("sub0_cc", W'(cc_q), W'(3'b100));
        cycle(0, 1, 2'd0, 64'd2, 64'd3, 0, 3'd3, 1);
        check("e_after_sub0", W'(out_cnd), W'(1'b1));

        // Logic op without CC update.
        cycle(0, 1, 2'd3, 64'hFF, 64'hFF, 0, 3'd0, 1);
        check("xor_result", out_result, '0);
        check("xor_flags", W'(out_flags), W'(3'b100));
        check("xor_cc_hold", W'(cc_q), W'(3'b100));

        // Back-pressure: first result (3-7 = -4) held while a CC-setting op waits.
        cycle(0, 1, 2'd1, 64'd7, 64'd3, 1, 3'd0, 1);
        for (int i = 0; i < 3; i++) begin
            cycle(0, 1, 2'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1, 3'd0, 0);
            check("bp_hold_result", out_result, 64'hFFFF_FFFF_FFFF_FFFC);
            check("bp_in_ready", W'(in_ready), '0);
            check("bp_cc_hold", W'(cc_q), W'(3'b010));
        end
        cycle(0, 1, 2'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1, 3'd0, 1);
        check("bp_release_result", out_result, '0);
        check("bp_release_cc", W'(cc_q), W'(3'b100));
        accepts = 0;
        for (int i = 0; i < 4; i++) begin
            cycle(0, 1, 2'(i), 64'(i + 1), 64'd100, 0, 3'(i), 1);
        end
        check("throughput", W'(accepts), W'(4));

        // Reset while stalled drops the pending result.
        cycle(0, 1, 2'd0, 64'd9, 64'd9, 1, 3'd0, 1);
        cycle(0, 0, 2'd0, 64'd0, 64'd0, 0, 3'd0, 0);
        cycle(1, 0, 2'd0, 64'd0, 64'd0, 0, 3'd0, 0);
        check("midrst_valid", W'(out_valid), '0);
        check("midrst_cc", W'(cc_q), W'(3'b100));
`ifdef EXEC_STATS_EN
        check("midrst_stat_ops", W'(stat_ops), '0);
`endif

        // Randomized traffic with random back-pressure and rare resets.
        for (int i = 0; i < 600; i++) begin
            cycle(($urandom_range(0, 99) == 0),
                  ($urandom_range(0, 3) != 0),
                  2'($urandom_range(0, 3)),
                  pick_operand(), pick_operand(),
                  1'($urandom_range(0, 1)),
                  3'($urandom_range(0, 7)),
                  ($urandom_range(0, 9) < 7));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_cc_execute.md
Name: alu_cc_execute

Overview:
- Registered execute stage of the 64-bit datapath.
- Takes decoded operands, runs add/sub/and/xor, and updates the condition-code register (ZF, SF, OF).
- Evaluates a branch/cmov condition against the pre-update condition codes.
- Presents a one-deep registered result to the memory stage over a valid/ready handshake.

Parameters:
- WIDTH, 64, operand/result width in bits; signed two's complement.
- CC_RESET, 3'b100, condition-code reset value {ZF,SF,OF}; ZF=1.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream operands valid.
- in_ready  out  1  stage can accept this cycle.
- in_op  in  2  0=ADD (b+a), 1=SUB (b-a), 2=AND, 3=XOR.
- in_a  in  WIDTH  operand A (valA / valC).
- in_b  in  WIDTH  operand B (valB).
- in_set_cc  in  1  update condition codes with this op's flags.
- in_cond  in  3  0=always, 1=le, 2=l, 3=e, 4=ne, 5=ge, 6=g, 7=never.
- out_valid  out  1  registered result valid.
- out_ready  in  1  downstream accepts result.
- out_result  out  WIDTH  registered valE.
- out_flags  out  3  {ZF,SF,OF} computed by this op, registered with the result.
- out_cnd  out  1  registered condition outcome.
- cc_q  out  3  architectural condition-code register.

Behaviour:
- Reset (rst=1 at edge): out_valid=0, out_result=0, out_flags=0, out_cnd=0, cc_q=CC_RESET. Reset overrides any accept or hold in the same cycle. A pending result is dropped.
- in_ready = !out_valid || out_ready. This is combinational; no dependence on in_valid.
- Accept = in_valid && in_ready.
  - On accept: register result, flags and cnd; set out_valid=1.
  - No accept and out_ready=1: out_valid clears.
- Hold: out_valid && !out_ready keeps all out_* stable.
- Latency: 1 cycle from accept to out_valid. Throughput is 1 op/cycle when out_ready is held high.
- Arithmetic is modulo 2^WIDTH.
  - ADD: b+a.
  - SUB: b+~a+1 (carry-in 1).
  - OF for ADD/SUB = carry into MSB XOR carry out of MSB.
  - AND/XOR: OF=0.
  - ZF = (result==0). SF = result[WIDTH-1].
- cc_q updates only on accept with in_set_cc=1, taking the new flags. Otherwise it holds, including during stalls.
- Condition is evaluated from cc_q before that cycle's update, so an op that sets CC and carries a condition sees the old CC.
  - le: (SF^OF)|ZF
  - l: SF^OF
  - e: ZF
  - ne: !ZF
  - ge: !(SF^OF)
  - g: !(SF^OF)&!ZF
- Inputs are ignored when in_valid=0. cc_q does not change without an accept.

Optional Feature:
- Macro: EXEC_STATS_EN.
- Defined: adds outputs stat_ops[31:0] and stat_ovf[31:0].
  - stat_ops increments on every accept.
  - stat_ovf increments on accepts whose computed OF=1.
  - Both wrap at 2^32 and clear on rst.
- Undefined: the ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Package alu_pkg holds:
  - op encodings (ALU_ADD, ALU_SUB, ALU_AND, ALU_XOR);
  - cond encodings (C_ALWAYS through C_NEVER);
  - CC bit indices (CC_ZF=2, CC_SF=1, CC_OF=0);
  - default CC_RESET.
- Sub-module alu_core: purely combinational. Computes the result and flags from op, a, b, using a ripple add with explicit carry-in. It must use the same OF rule as bit64_adder.
- alu_cc_execute holds the pipeline register, handshake, cc_q and condition logic.

Test Plan:
- Reset: drive rst for 2 cycles while in_valid=1 -> out_valid=0, out_result=0, cc_q=3'b100; in_ready=1 after release.
- Signed overflow: ADD a=1, b=0x7FFF_FFFF_FFFF_FFFF, set_cc=1 -> next cycle out_result=0x8000_0000_0000_0000, out_flags=3'b011, cc_q=3'b011.
- SUB to zero: SUB a=5, b=5, set_cc=1, cond=e, with prior cc_q=3'b000 -> out_result=0, out_cnd=0 (old CC), cc_q=3'b100. A following cond=e op gives out_cnd=1.
- Back-pressure: out_ready=0 for 3 cycles with continuous valid input -> first result held stable, in_ready=0. The second op is neither accepted nor allowed to change cc_q until out_ready=1. Then 1 op/cycle.
- Logic op: XOR a=0xFF, b=0xFF, set_cc=0 -> out_result=0, out_flags=3'b100, cc_q unchanged.
- Reset mid-stall: out_valid=1, out_ready=0, assert rst -> next cycle out_valid=0, cc_q=CC_RESET. With EXEC_STATS_EN defined, stat_ops=0.
